// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and clamp helper for the up/down counter.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef logic [3:0] bcd_digit_t;

    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: clear > load > enabled up/down step, with 9/0 detect.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  bcd_digit_t d,
    input  logic       up,
    input  logic       dn,
    input  logic       en,
    output bcd_digit_t q,
    output logic       is_nine,
    output logic       is_zero
);

    assign is_nine = (q == BCD_MAX);
    assign is_zero = (q == BCD_MIN);

    // Up and dn are never both high; the top resolves INC/DEC before this point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= BCD_MIN;
        else if (clr)
            q <= BCD_MIN;
        else if (load)
            q <= bcd_clamp(d);
        else if (en && up)
            q <= is_nine ? BCD_MIN : q + 4'd1;
        else if (en && dn)
            q <= is_zero ? BCD_MAX : q - 4'd1;
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load, wrap/saturate mode and carry/borrow pulses.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int WRAP_DEFAULT = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CLR,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   D,
    input  logic                  INC,
    input  logic                  DEC,
    input  logic                  WRAP,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  CARRY,
    output logic                  BORROW,
    output logic                  ZERO,
    output logic                  FULL
);

    // WRAP_DEFAULT is consumed by integrating logic; only its legality is checked here.
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_updown_counter: DIGITS must be 1..8");
    end
    if (WRAP_DEFAULT != 0 && WRAP_DEFAULT != 1) begin : g_bad_wrap
        $error("bcd_updown_counter: WRAP_DEFAULT must be 0 or 1");
    end

    logic [DIGITS-1:0][3:0] dig_q;
    logic [DIGITS-1:0]      nine;
    logic [DIGITS-1:0]      zero;
    logic [DIGITS-1:0]      en;
    logic                   all_nine;
    logic                   all_zero;
    logic                   cnt_up;
    logic                   cnt_dn;
    logic                   carry_q;
    logic                   borrow_q;

    assign all_nine = &nine;
    assign all_zero = &zero;

    // Saturate mode simply suppresses the step that would wrap.
    assign cnt_up = INC & ~DEC & ~(all_nine & ~WRAP);
    assign cnt_dn = DEC & ~INC & ~(all_zero & ~WRAP);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_en0
            assign en[k] = 1'b1;
        end else begin : g_enk
            assign en[k] = en[k-1] & (cnt_up ? nine[k-1] : zero[k-1]);
        end

        bcd_digit u_digit (
            .clk     (CLK),
            .rst_n   (RST_N),
            .clr     (CLR),
            .load    (LOAD),
            .d       (D[4*k +: 4]),
            .up      (cnt_up),
            .dn      (cnt_dn),
            .en      (en[k]),
            .q       (dig_q[k]),
            .is_nine (nine[k]),
            .is_zero (zero[k])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            carry_q  <= ~CLR & ~LOAD & cnt_up & all_nine;
            borrow_q <= ~CLR & ~LOAD & cnt_dn & all_zero;
        end
    end

    assign Q      = dig_q;
    assign CARRY  = carry_q;
    assign BORROW = borrow_q;
    assign ZERO   = all_zero;
    assign FULL   = all_nine;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed plus random checks of a 2-digit BCD counter against an integer model.
module tb_bcd_updown_counter;

    localparam int DIGITS = 2;
    localparam int MOD    = 100;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic                CLR, LOAD, INC, DEC, WRAP;
    logic [4*DIGITS-1:0] D;
    logic [4*DIGITS-1:0] Q;
    logic                CARRY, BORROW, ZERO, FULL;

    int tests = 0;
    int fails = 0;

    // Reference state: plain integer count plus expected flag pulses.
    int val = 0;
    bit exp_c = 0;
    bit exp_b = 0;

    bcd_updown_counter #(.DIGITS(DIGITS), .WRAP_DEFAULT(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LOAD(LOAD), .D(D),
        .INC(INC), .DEC(DEC), .WRAP(WRAP), .Q(Q), .CARRY(CARRY),
        .BORROW(BORROW), .ZERO(ZERO), .FULL(FULL)
    );

    always #5 CLK = ~CLK;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int load_val(input logic [4*DIGITS-1:0] dv);
        int r;
        int p;
        int n;
        r = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            n = int'(dv[4*i +: 4]);
            if (n > 9) n = 9;
            r = r + n * p;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".Q"},      32'(Q),      32'(to_bcd(val)));
        chk({tag, ".CARRY"},  32'(CARRY),  32'(exp_c));
        chk({tag, ".BORROW"}, 32'(BORROW), 32'(exp_b));
        chk({tag, ".ZERO"},   32'(ZERO),   32'(val == 0));
        chk({tag, ".FULL"},   32'(FULL),   32'(val == MOD - 1));
    endtask

    // Apply one cycle of inputs, advance the model, check after the edge.
    task automatic step(input string tag, input logic clr, input logic load,
                        input logic [4*DIGITS-1:0] dv, input logic inc,
                        input logic dec, input logic wrap);
        CLR = clr; LOAD = load; D = dv; INC = inc; DEC = dec; WRAP = wrap;
        exp_c = 0;
        exp_b = 0;
        if (clr) val = 0;
        else if (load) val = load_val(dv);
        else if (inc && !dec) begin
            if (val == MOD - 1) begin
                if (wrap) begin val = 0; exp_c = 1; end
            end else val = val + 1;
        end else if (dec && !inc) begin
            if (val == 0) begin
                if (wrap) begin val = MOD - 1; exp_b = 1; end
            end else val = val - 1;
        end
        @(posedge CLK);
        #1;
        chk_all(tag);
    endtask

    initial begin
        RST_N = 1'b0; CLR = 0; LOAD = 0; D = '0; INC = 1; DEC = 0; WRAP = 1;
        repeat (2) @(posedge CLK);
        #1;
        chk_all("reset");
        RST_N = 1'b1;

        // Count, clear
        step("inc1", 0, 0, 8'h00, 1, 0, 1);
        step("inc2", 0, 0, 8'h00, 1, 0, 1);
        step("inc3", 0, 0, 8'h00, 1, 0, 1);
        chk("inc3.lit", 32'(Q), 32'h03);
        step("clr", 1, 0, 8'h00, 0, 0, 1);
        chk("clr.lit", 32'(Q), 32'h00);

        // Decimal carry between digits
        step("ld08", 0, 1, 8'h08, 0, 0, 1);
        step("dc1", 0, 0, 8'h00, 1, 0, 1);
        step("dc2", 0, 0, 8'h00, 1, 0, 1);
        chk("dc2.lit", 32'(Q), 32'h10);
        step("dc3", 0, 0, 8'h00, 1, 0, 1);

        // Wrap up
        step("ld98", 0, 1, 8'h98, 0, 0, 1);
        step("wu1", 0, 0, 8'h00, 1, 0, 1);
        step("wu2", 0, 0, 8'h00, 1, 0, 1);
        chk("wu2.carry", 32'(CARRY), 32'h1);
        step("wu3", 0, 0, 8'h00, 0, 0, 1);

        // Wrap down
        step("wd1", 0, 0, 8'h00, 0, 1, 1);
        chk("wd1.lit", 32'(Q), 32'h99);
        step("wd2", 0, 0, 8'h00, 0, 1, 1);

        // Saturate at both ends; INC and DEC together hold
        step("ld99", 0, 1, 8'h99, 0, 0, 0);
        step("sat_up", 0, 0, 8'h00, 1, 0, 0);
        step("clr2", 1, 0, 8'h00, 0, 0, 0);
        step("sat_dn", 0, 0, 8'h00, 0, 1, 0);
        step("ld45", 0, 1, 8'h45, 0, 0, 0);
        step("both", 0, 0, 8'h00, 1, 1, 1);
        chk("both.lit", 32'(Q), 32'h45);

        // Load clamp and priority
        step("clamp", 0, 1, 8'hF3, 1, 0, 1);
        chk("clamp.lit", 32'(Q), 32'h93);
        step("prio", 1, 1, 8'h55, 1, 0, 1);

        // Asynchronous reset while a carry pulse is showing
        step("ld99b", 0, 1, 8'h99, 0, 0, 1);
        step("wrapb", 0, 0, 8'h00, 1, 0, 1);
        RST_N = 1'b0;
        #2;
        val = 0; exp_c = 0; exp_b = 0;
        chk_all("async_rst");
        RST_N = 1'b1;

        // Random traffic, biased so both boundaries are visited often
        for (int n = 0; n < 400; n++) begin
            logic c, l, i, d, w;
            logic [4*DIGITS-1:0] dv;
            c  = ($urandom_range(0, 29) == 0);
            l  = ($urandom_range(0, 9) == 0);
            i  = ($urandom_range(0, 1) == 1);
            d  = ($urandom_range(0, 2) == 0);
            w  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: dv = 8'h99;
                1: dv = 8'h00;
                default: dv = 8'($urandom);
            endcase
            step("rand", c, l, dv, i, d, w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised synchronous multi-digit BCD up/down counter, the next generation of the single-digit decade counter used in the timer.
- All digits sit in one clock domain; counting is driven by per-cycle strobes, not by input edges.
- Adds parallel load, a selectable wrap/saturate mode, and registered carry/borrow pulses.
- Adds ZERO and FULL status flags, so timer stages chain or compare without ripple clocks.

Parameters:
DIGITS, 4, number of BCD digits; range 1..8
WRAP_DEFAULT, 1, value of the wrap/saturate mode after reset (1 = wrap, 0 = saturate)

Ports:
CLK  input  1  single clock; all state changes on its rising edge
RST_N  input  1  asynchronous, active-low reset
CLR  input  1  synchronous clear, active high
LOAD  input  1  synchronous parallel load, active high
D  input  4*DIGITS  load value, packed BCD; digit 0 in D[3:0]
INC  input  1  count-up strobe, one step per cycle while high
DEC  input  1  count-down strobe, one step per cycle while high
WRAP  input  1  mode select: 1 = wrap, 0 = saturate; sampled every cycle
Q  output  4*DIGITS  count, packed BCD; digit 0 is least significant
CARRY  output  1  registered one-cycle pulse on wrap from all-9s to all-0s
BORROW  output  1  registered one-cycle pulse on wrap from all-0s to all-9s
ZERO  output  1  combinational; Q == 0
FULL  output  1  combinational; every digit of Q == 9

Behaviour:
- Reset (RST_N low, asynchronous):
  - Q = 0, CARRY = 0, BORROW = 0.
  - WRAP_DEFAULT is used only by integrating logic; the WRAP port always governs behaviour.
  - Deassertion takes effect on the next CLK rising edge after RST_N goes high.
- Priority on each rising edge: CLR > LOAD > (INC xor DEC). Nothing asserted means hold.
- CLR: Q := 0. CARRY and BORROW are 0 next cycle.
- LOAD:
  - Q := D, digit by digit; any digit value > 9 is clamped to 9.
  - CARRY and BORROW are 0 next cycle.
  - INC and DEC are ignored that cycle.
- INC and DEC both high: no change, no flags. Counts as hold.
- INC only:
  - Digit 0 increments.
  - Digit k increments iff every lower digit is 9; a digit that rolls over goes from 9 to 0.
  - Q was FULL and WRAP = 1: Q := 0 and CARRY = 1 for exactly the following cycle.
  - Q was FULL and WRAP = 0: Q holds and CARRY stays 0.
- DEC only:
  - Digit k decrements iff every lower digit is 0; a digit that rolls under goes from 0 to 9.
  - Q was ZERO and WRAP = 1: Q := all 9s and BORROW = 1 for the following cycle.
  - Q was ZERO and WRAP = 0: Q holds and BORROW stays 0.
- Latency:
  - Q and CARRY/BORROW update on the same edge that samples the strobe (1 cycle).
  - ZERO and FULL follow Q combinationally.
- CARRY and BORROW never assert together. Each is high for at most one cycle per wrap event.
- INC held high continuously counts every cycle. With WRAP = 1, CARRY pulses once every 10^DIGITS cycles.
- Every digit of Q is always in 0..9; no state outside BCD is reachable.
- Reset asserted mid-count clears Q and any pending CARRY/BORROW pulse immediately.

Decomposition:
- Shared package bcd_pkg:
  - constants BCD_MAX = 4'd9 and BCD_MIN = 4'd0;
  - digit typedef bcd_digit_t (4 bits);
  - function bcd_clamp (returns the digit if ≤ 9, else 9).
- One sub-module, bcd_digit: single-digit register with clear, load, up, down and enable inputs.
  - Outputs: its digit, is_nine, is_zero.
  - Instantiated DIGITS times.
  - Per-digit enables are built from a prefix-AND of the is_nine/is_zero outputs of lower digits.
- The top level owns WRAP/saturate gating, the flag registers, and the ZERO/FULL reduction.

Test Plan:
1. Reset and CLR: DIGITS=2, RST_N low with INC high -> Q=0x00, CARRY=BORROW=0, ZERO=1. Release, 3 INC cycles, then CLR -> Q=0x03, then 0x00.
2. Decimal carry: LOAD D=0x08, then INC for 3 cycles -> Q = 0x09, 0x10, 0x11; CARRY stays 0.
3. Wrap up: LOAD 0x98, INC for 2 cycles with WRAP=1 -> Q = 0x99 (FULL=1), then 0x00; CARRY=1 exactly one cycle.
4. Wrap down: Q=0x00, WRAP=1, DEC one cycle -> Q=0x99, BORROW=1 for one cycle. DEC again -> Q=0x98, BORROW=0.
5. Saturate: WRAP=0. Q=0x99 plus INC, and Q=0x00 plus DEC -> Q unchanged, CARRY=BORROW=0. INC and DEC together on Q=0x45 -> 0x45 holds.
6. Load clamp and priority: LOAD D=0xF3 with INC=1 -> Q=0x93. CLR and LOAD together with D=0x55 -> Q=0x00.
